word_packer: RTL and testbench
==============================

Name: word_packer

Overview:
- Upstream feeder for the vocabulary matcher: converts a byte-serial text stream into fixed-width, MSB-first character words on the matcher's `word` input.
- Splits on a delimiter character and on end-of-text.
- Words longer than WORD_LENGTH are emitted as consecutive full chunks.
- Valid/ready handshake on both sides; one output word buffered.

Parameters:
- WORD_LENGTH, 3, characters per output word.
- DATA_WIDTH, 8, bits per character.
- DELIM, 8'h20, delimiter character (ASCII space).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- in_data  input  DATA_WIDTH  incoming character.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  final byte of the text.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- word  output  WORD_LENGTH*DATA_WIDTH  packed word; char 0 in the MSBs; unused slots zero.
- word_len  output  $clog2(WORD_LENGTH+1)  number of valid chars in word (0..WORD_LENGTH).
- word_full  output  1  word was closed by reaching WORD_LENGTH, not by delimiter or last.
- word_last  output  1  word closes the text.
- word_valid  output  1  word/len/flags valid.
- word_ready  input  1  consumer accepts when word_valid && word_ready.

Interface decision (fixed): one clock, `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - word=0, word_len=0, word_full=0, word_last=0, word_valid=0.
  - internal count=0; state=FILL.
  - in_ready=1 after release.
- Reset mid-operation discards any partial word and any held output.
- States: FILL, EMIT.
- FILL:
  - in_ready=1, word_valid=0.
  - On each accepted byte b, with count = chars buffered:
    - b==DELIM, count>0: close word (len=count, full=0, last=in_last) -> EMIT.
    - b==DELIM, count==0, in_last=0: drop byte. Consecutive or leading delimiters collapse.
    - b==DELIM, count==0, in_last=1: close empty word (len=0, word=0, last=1) -> EMIT.
    - b!=DELIM: write b into slot `count` (bits [(WORD_LENGTH-count)*DATA_WIDTH-1 -: DATA_WIDTH]); count+1.
      - If the new count==WORD_LENGTH: close (full=1, last=in_last) -> EMIT.
      - Else if in_last=1: close (full=0, last=1) -> EMIT.
      - Else stay in FILL.
- EMIT:
  - word_valid=1, in_ready=0.
  - word, word_len, word_full and word_last are held stable until the handshake.
  - On word_ready=1: clear buffer to 0, count=0, flags=0 -> FILL next cycle.
  - word_ready may be high on the first EMIT cycle; that gives a one-cycle handshake.
- Latency: word_valid asserts the cycle after the closing byte is accepted.
- Throughput: at most one byte per cycle, plus at least one input bubble per emitted word.
- Width rules:
  - count and word_len are $clog2(WORD_LENGTH+1) bits; count never exceeds WORD_LENGTH.
  - Closing at WORD_LENGTH precedes any further write, so a slot index never wraps.
- A delimiter immediately after a full chunk is a count==0 delimiter and is dropped. No empty word is emitted unless in_last is set.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.

Decomposition:
- Shared package tokenizer_pkg holds:
  - constants DATA_WIDTH, WORD_LENGTH, DELIM_CHAR;
  - typedef char_t = logic[DATA_WIDTH-1:0];
  - typedef word_t = logic[WORD_LENGTH*DATA_WIDTH-1:0];
  - enum packer_state_e {FILL, EMIT}.
- The matcher imports the same word_t.
- No sub-module. Slot writes and the FSM are a single always_ff plus a small combinational close decode.

Test Plan:
- Stream 'H','e','l' (in_last=0), word_ready=1 -> word=24'h48656C, len=3, full=1, last=0, one cycle after 'l'.
- Stream 'H','i',' ' -> word=24'h486900, len=2, full=0.
- Stream "Hello" with in_last on 'o':
  - first word=24'h48656C, full=1;
  - second word=24'h6C6F00, len=2, last=1.
- Stream ' ',' ','A',' ' -> exactly one word 24'h410000, len=1; leading spaces produce no output.
- Close "abc", hold word_ready=0 for 5 cycles:
  - word stays 24'h616263 and word_valid=1 throughout;
  - in_ready=0 throughout;
  - on release, FILL resumes the next cycle.
- Feed 'x','y', pulse rst_n low asynchronously between clock edges:
  - all outputs 0 immediately;
  - then 'z',' ' -> word=24'h7A0000, len=1 (no stale 'x','y').
- Lone ' ' with in_last=1 -> word=0, len=0, last=1, word_valid=1.

Source files
------------

// File: rtl/tokenizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tokenizer_pkg
// Brief    : Shared character/word types and constants for the tokenizer path
//            (word_packer feeding the vocabulary matcher).
// Revision : 1.0 - initial release
// ============================================================================
package tokenizer_pkg;

    localparam int              DATA_WIDTH  = 8;
    localparam int              WORD_LENGTH = 3;
    localparam logic [7:0]      DELIM_CHAR  = 8'h20;

    typedef logic [DATA_WIDTH-1:0]             char_t;
    typedef logic [WORD_LENGTH*DATA_WIDTH-1:0] word_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } packer_state_e;

endpackage
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// Module   : word_packer
// Brief    : Packs a byte-serial text stream into fixed-width MSB-first words,
//            splitting on a delimiter, on end-of-text and on word overflow.
//            One output word is buffered; in_ready drops while it is held.
// Revision : 1.0 - initial release
// ============================================================================
module word_packer #(
    parameter int                    WORD_LENGTH = tokenizer_pkg::WORD_LENGTH,
    parameter int                    DATA_WIDTH  = tokenizer_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] DELIM       = tokenizer_pkg::DELIM_CHAR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    output logic [$clog2(WORD_LENGTH+1)-1:0]  word_len,
    output logic                              word_full,
    output logic                              word_last,
    output logic                              word_valid,
    input  logic                              word_ready
);

    import tokenizer_pkg::*;

    localparam int CW = $clog2(WORD_LENGTH + 1);
    localparam int WW = WORD_LENGTH * DATA_WIDTH;

    packer_state_e   state_q, state_n;
    logic [WW-1:0]   buf_q,   buf_n;
    logic [CW-1:0]   count_q, count_n;
    logic            full_q,  full_n;
    logic            last_q,  last_n;

    logic            accept;
    logic            is_delim;
    logic [CW-1:0]   count_inc;
    logic [WW-1:0]   buf_written;

    assign in_ready   = (state_q == FILL);
    assign word_valid = (state_q == EMIT);
    assign word       = buf_q;
    assign word_len   = count_q;
    assign word_full  = full_q;
    assign word_last  = last_q;

    assign accept    = in_valid && (state_q == FILL);
    assign is_delim  = (in_data == DELIM);
    assign count_inc = count_q + CW'(1);

    // Buffer with the incoming character dropped into slot `count` (slot 0 = MSBs)
    always_comb begin
        buf_written = buf_q;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (count_q == CW'(i)) begin
                buf_written[(WORD_LENGTH-i)*DATA_WIDTH-1 -: DATA_WIDTH] = in_data;
            end
        end
    end

    // Close decode and next-state: decides when a word is complete and how it is flagged
    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        count_n = count_q;
        full_n  = full_q;
        last_n  = last_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (is_delim) begin
                        if (count_q != '0) begin
                            full_n  = 1'b0;
                            last_n  = in_last;
                            state_n = EMIT;
                        end else if (in_last) begin
                            // Text ended on a bare delimiter: emit an empty terminator word
                            buf_n   = '0;
                            full_n  = 1'b0;
                            last_n  = 1'b1;
                            state_n = EMIT;
                        end
                    end else begin
                        buf_n   = buf_written;
                        count_n = count_inc;
                        if (count_inc == CW'(WORD_LENGTH)) begin
                            full_n  = 1'b1;
                            last_n  = in_last;
                            state_n = EMIT;
                        end else if (in_last) begin
                            full_n  = 1'b0;
                            last_n  = 1'b1;
                            state_n = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                if (word_ready) begin
                    buf_n   = '0;
                    count_n = '0;
                    full_n  = 1'b0;
                    last_n  = 1'b0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // State, word buffer and flags; async reset discards partial and held words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            buf_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            count_q <= count_n;
            full_q  <= full_n;
            last_q  <= last_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_packer
// Brief    : Directed self-checking bench for word_packer with an expected-word
//            scoreboard popped on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [23:0] word;
    logic [1:0]  word_len;
    logic        word_full;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;

    typedef struct packed {
        logic [23:0] w;
        logic [1:0]  len;
        logic        full;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    word_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .word       (word),
        .word_len   (word_len),
        .word_full  (word_full),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] w, input logic [1:0] len,
                        input logic full, input logic last);
        exp_t e;
        e.w = w; e.len = len; e.full = full; e.last = last;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is accepted
    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: every output handshake must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {8'h0, word}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_word", {8'h0, word},      {8'h0, e.w});
                chk("sb_len",  {30'h0, word_len}, {30'h0, e.len});
                chk("sb_full", {31'h0, word_full}, {31'h0, e.full});
                chk("sb_last", {31'h0, word_last}, {31'h0, e.last});
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        word_ready = 1'b1;
        #12;
        chk("rst_word",       {8'h0, word},       32'h0);
        chk("rst_len",        {30'h0, word_len},  32'h0);
        chk("rst_valid",      {31'h0, word_valid}, 32'h0);
        chk("rst_full_last",  {30'h0, word_full, word_last}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Full chunk "Hel", valid the cycle after 'l'
        push(24'h48656C, 2'd3, 1'b1, 1'b0);
        send(8'h48, 1'b0);
        send(8'h65, 1'b0);
        send(8'h6C, 1'b0);
        chk("latency_valid", {31'h0, word_valid}, 32'h1);
        chk("latency_in_ready", {31'h0, in_ready}, 32'h0);
        idle(1);
        chk("one_cycle_hs", {31'h0, word_valid}, 32'h0);

        // "Hi " closed by delimiter
        push(24'h486900, 2'd2, 1'b0, 1'b0);
        send(8'h48, 1'b0);
        send(8'h69, 1'b0);
        send(8'h20, 1'b0);
        idle(2);

        // "Hello" with last on 'o': full chunk then tail
        push(24'h48656C, 2'd3, 1'b1, 1'b0);
        push(24'h6C6F00, 2'd2, 1'b0, 1'b1);
        send(8'h48, 1'b0);
        send(8'h65, 1'b0);
        send(8'h6C, 1'b0);
        send(8'h6C, 1'b0);
        send(8'h6F, 1'b1);
        idle(2);

        // Leading/trailing spaces around 'A': exactly one word
        push(24'h410000, 2'd1, 1'b0, 1'b0);
        send(8'h20, 1'b0);
        send(8'h20, 1'b0);
        chk("leading_delim_no_valid", {31'h0, word_valid}, 32'h0);
        send(8'h41, 1'b0);
        send(8'h20, 1'b0);
        idle(2);

        // Backpressure: "abc" held for 5 cycles
        word_ready = 1'b0;
        push(24'h616263, 2'd3, 1'b1, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_word",     {8'h0, word},        32'h00616263);
            chk("hold_valid",    {31'h0, word_valid}, 32'h1);
            chk("hold_in_ready", {31'h0, in_ready},   32'h0);
        end
        @(posedge clk); #1;
        word_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_fill", {31'h0, in_ready}, 32'h1);
        chk("release_valid", {31'h0, word_valid}, 32'h0);

        // Async reset mid-word discards 'x','y'
        send(8'h78, 1'b0);
        send(8'h79, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_word",  {8'h0, word},                     32'h0);
        chk("arst_len",   {30'h0, word_len},                32'h0);
        chk("arst_flags", {29'h0, word_full, word_last, word_valid}, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(24'h7A0000, 2'd1, 1'b0, 1'b0);
        send(8'h7A, 1'b0);
        send(8'h20, 1'b0);
        idle(2);

        // Lone delimiter with last: empty terminator word
        push(24'h000000, 2'd0, 1'b0, 1'b1);
        send(8'h20, 1'b1);
        chk("empty_last_valid", {31'h0, word_valid}, 32'h1);
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
